// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for cache fill traffic. Arbitrates the icache fetch
//   port and the dcache read/write port onto a single RAM port, one
//   transaction at a time. It also forces completion of a transaction when the
//   RAM reports an error or stays unresponsive for TIMEOUT cycles.
//
//   A completion is signalled by the owning port's wait going low for exactly
//   one cycle. The load data is valid in that same cycle, and the cache samples
//   it combinationally.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          icache fetch request and byte address
//   iwait, iload         0 = fetch completes this cycle; fetched word
//   dREN, dWEN           dcache read / write request (both high = write)
//   daddr, dstore        dcache byte address and write data
//   dwait, dload         0 = data access completes this cycle; read word
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM word-aligned address and write data
//   ramload, ramstate    RAM read data; status 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   err                  sticky error flag (RAM error or timeout seen)
module mem_responder #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2
  } state_t;

  localparam int               CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT);
  localparam logic [1:0]       RS_ACCESS = 2'd2;
  localparam logic [1:0]       RS_ERROR  = 2'd3;

  state_t           state_q, state_d;
  logic             iprio_q, iprio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             dreq;

  // The RAM is word addressed, so the byte-offset bits of the request
  // addresses are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{iaddr[1:0], daddr[1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    iprio_d  = iprio_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dreq     = dREN | dWEN;

    case (state_q)
      IDLE: begin
        // The counter is cleared here, so it always starts at 0 on entry to
        // a request state.
        cnt_d = '0;
        if (dreq && !(iREN && iprio_q)) begin
          state_d = DREQ;
        end else if (iREN) begin
          state_d = IREQ;
        end
      end

      IREQ: begin
        ramREN  = 1'b1;
        ramaddr = {iaddr[31:2], 2'b00};
        if (!iREN) begin
          // Abort: the requester withdrew, so no completion strobe is given.
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          iprio_d = 1'b0;
          state_d = IDLE;
        end else if (ramstate == RS_ERROR || cnt_q == CNT_TO) begin
          iwait   = 1'b0;
          iload   = BADWORD;
          err_d   = 1'b1;
          iprio_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      DREQ: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = {daddr[31:2], 2'b00};
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          dwait = 1'b0;
          dload = dWEN ? 32'd0 : ramload;
          // An icache request that waited behind this access gets the next
          // grant. This prevents a busy dcache from starving it.
          if (iREN) iprio_d = 1'b1;
          state_d = IDLE;
        end else if (ramstate == RS_ERROR || cnt_q == CNT_TO) begin
          dwait = 1'b0;
          dload = BADWORD;
          err_d = 1'b1;
          if (iREN) iprio_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      iprio_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iprio_q <= iprio_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. The stimulus pushes the expected completions, in
// predicted grant order, into a scoreboard queue. It also pushes the matching
// RAM behaviour plans into a plan queue that a RAM model consumes. A monitor
// pops the scoreboard whenever iwait or dwait goes low and compares.
module tb_mem_responder;

  localparam int          TO  = 8;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  localparam int K_ACC  = 0;
  localparam int K_ERR  = 1;
  localparam int K_HANG = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        err;

  mem_responder #(.TIMEOUT(TO), .BADWORD(BAD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] load;
    bit          bad;
    int          cycles;
  } exp_t;

  typedef struct {
    int busy;
    int kind;
  } plan_t;

  exp_t        sbq[$];
  plan_t       planq[$];
  logic [31:0] mem    [0:63];  // contents of the RAM model
  logic [31:0] refmem [0:63];  // reference model's view of memory
  bit          ref_prio = 1'b0;
  bit          exp_err  = 1'b0;
  int          en_cnt   = 0;
  int          nchk     = 0;
  int          nerr     = 0;
  plan_t       tp;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // RAM model. It starts a new plan on each rising edge of its enables. It
  // answers BUSY for plan.busy cycles, then ACCESS or ERROR. A HANG plan
  // answers BUSY forever.
  int  busy_left;
  int  kind_cur;
  bit  active = 1'b0;
  always @(posedge CLK) begin
    #2;
    if (!nRST) begin
      active   = 1'b0;
      ramstate = 2'd0;
    end else if (ramREN || ramWEN) begin
      if (!active) begin
        if (planq.size() > 0) tp = planq.pop_front();
        else begin tp.busy = 0; tp.kind = K_ACC; end
        busy_left = tp.busy;
        kind_cur  = tp.kind;
        active    = 1'b1;
      end
      if (kind_cur == K_HANG || busy_left > 0) begin
        ramstate = 2'd1;
        ramload  = $urandom;
        if (busy_left > 0) busy_left--;
      end else if (kind_cur == K_ACC) begin
        ramstate = 2'd2;
        ramload  = mem[ramaddr[7:2]];
        if (ramWEN) mem[ramaddr[7:2]] = ramstore;
      end else begin
        ramstate = 2'd3;
        ramload  = $urandom;
      end
    end else begin
      active   = 1'b0;
      ramstate = 2'd0;
      ramload  = $urandom;
    end
  end

  // Monitor
  exp_t me;
  always @(negedge CLK) begin
    if (!nRST) begin
      exp_err = 1'b0;
      en_cnt  = 0;
    end else begin
      if (ramREN || ramWEN) en_cnt++;
      else en_cnt = 0;
      if (!iwait && !dwait) begin
        nchk++; nerr++;
        $display("FAIL both_strobe: iwait=%b dwait=%b, at most one may be low (t=%0t)", iwait, dwait, $time);
      end else if (!iwait || !dwait) begin
        if (sbq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_strobe: iwait=%b dwait=%b with no completion expected (t=%0t)", iwait, dwait, $time);
        end else begin
          me = sbq.pop_front();
          chk("owner_is_d", 32'(!dwait), 32'(me.is_d));
          chk(me.is_d ? "dload" : "iload", me.is_d ? dload : iload, me.load);
          chk("ramaddr", ramaddr, me.addr);
          chk("ramWEN", 32'(ramWEN), 32'(me.is_d && me.wr));
          chk("ramREN", 32'(ramREN), 32'(!(me.is_d && me.wr)));
          if (me.is_d && me.wr) chk("ramstore", ramstore, me.data);
          chk("err_before", 32'(err), 32'(exp_err));
          chk("latency", en_cnt, me.cycles);
          exp_err = exp_err | me.bad;
          en_cnt  = 0;
        end
      end
    end
  end

  function automatic int rand_kind();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return K_ACC;
    if (r < 85) return K_ERR;
    return K_HANG;
  endfunction

  task automatic push_one(input bit is_d, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int b, input int k);
    plan_t p;
    exp_t  e;
    p.busy = b;
    p.kind = k;
    planq.push_back(p);
    e.is_d   = is_d;
    e.wr     = wr;
    e.addr   = {a[31:2], 2'b00};
    e.data   = d;
    e.bad    = (k != K_ACC);
    e.cycles = (k == K_HANG) ? TO + 1 : b + 1;
    e.load   = e.bad ? BAD : (wr ? 32'd0 : refmem[a[7:2]]);
    if (wr && !e.bad) refmem[a[7:2]] = d;
    sbq.push_back(e);
  endtask

  // Predict the completions for n_i fetches and n_d data accesses whose
  // requests stay held until served. When both ports are pending, the data
  // port wins unless the fetch waited through the previous data completion.
  // busy/kind < 0 picks them randomly per transaction.
  task automatic predict(input int n_i, input int n_d, input bit wr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input int busy, input int kind);
    int ri;
    int rd;
    int b;
    int k;
    ri = n_i;
    rd = n_d;
    while (ri > 0 || rd > 0) begin
      b = (busy < 0) ? int'($urandom_range(0, 4)) : busy;
      k = (kind < 0) ? rand_kind() : kind;
      if (ri > 0 && (rd == 0 || ref_prio)) begin
        push_one(1'b0, 1'b0, ia, 32'd0, b, k);
        ref_prio = 1'b0;
        ri--;
      end else begin
        push_one(1'b1, wr, da, ds, b, k);
        if (ri > 0) ref_prio = 1'b1;
        rd--;
      end
    end
  endtask

  // Hold each port's request until that port has seen its number of completions.
  task automatic serve(input int n_i, input int n_d, input bit wr, input bit both,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds);
    int ci;
    int cd;
    int cyc;
    ci = 0; cd = 0; cyc = 0;
    iaddr = ia; daddr = da; dstore = ds;
    while ((ci < n_i || cd < n_d) && cyc < 200) begin
      @(posedge CLK); #1;
      iREN = (ci < n_i);
      dREN = (cd < n_d) && (!wr || both);
      dWEN = (cd < n_d) && wr;
      @(negedge CLK);
      if (!iwait) ci++;
      if (!dwait) cd++;
      cyc++;
    end
    if (ci < n_i || cd < n_d) begin
      nchk++; nerr++;
      $display("FAIL serve_timeout: completions i=%0d d=%0d, required i=%0d d=%0d", ci, cd, n_i, n_d);
    end
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  int          mode, ni, nd;
  bit          rwr, rboth;
  logic [31:0] ra, rb, rd_;

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = $urandom;
      refmem[i] = mem[i];
    end
    mem[17]    = 32'h1234;
    refmem[17] = 32'h1234;

    #12;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // fetch 0x44, immediate ACCESS
    predict(1, 0, 1'b0, 32'h44, 32'h0, 32'h0, 0, K_ACC);
    serve(1, 0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0);
    // write 0x103 after three BUSY cycles
    predict(0, 1, 1'b1, 32'h0, 32'h103, 32'hCAFE, 3, K_ACC);
    serve(0, 1, 1'b1, 1'b0, 32'h0, 32'h103, 32'hCAFE);
    // both ports held: D, I, D, I
    predict(2, 2, 1'b0, 32'h08, 32'h0C, 32'h0, 1, K_ACC);
    serve(2, 2, 1'b0, 1'b0, 32'h08, 32'h0C, 32'h0);
    // fetch with RAM stuck BUSY -> timeout
    predict(1, 0, 1'b0, 32'h20, 32'h0, 32'h0, 0, K_HANG);
    serve(1, 0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
    // data read answered with ERROR
    predict(0, 1, 1'b0, 32'h0, 32'h24, 32'h0, 0, K_ERR);
    serve(0, 1, 1'b0, 1'b0, 32'h0, 32'h24, 32'h0);

    // fetch withdrawn while RAM is BUSY
    tp.busy = 0; tp.kind = K_HANG;
    planq.push_back(tp);
    iaddr = 32'h30;
    @(posedge CLK); #1;
    iREN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    iREN = 1'b0;
    @(negedge CLK);
    chk("abort_no_strobe", 32'(iwait), 32'd1);
    @(negedge CLK);
    chk("abort_idle_ramREN", 32'(ramREN), 32'd0);

    // randomized traffic
    for (int t = 0; t < 120; t++) begin
      mode  = $urandom_range(0, 3);
      ni    = (mode != 1) ? 1 : 0;
      nd    = (mode != 0) ? 1 : 0;
      rwr   = 1'($urandom_range(0, 1));
      rboth = 1'($urandom_range(0, 1));
      ra    = $urandom_range(0, 63);
      rb    = $urandom_range(0, 63);
      rd_   = $urandom;
      predict(ni, nd, rwr, ra, rb, rd_, -1, -1);
      serve(ni, nd, rwr, rboth, ra, rb, rd_);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    // asynchronous reset in the middle of a data write
    tp.busy = 0; tp.kind = K_HANG;
    planq.push_back(tp);
    daddr = 32'h10; dstore = 32'h55;
    @(posedge CLK); #1;
    dWEN = 1'b1;
    repeat (3) @(posedge CLK);
    chk("err_sticky", 32'(err), 32'd1);
    chk("midreset_ramWEN_before", 32'(ramWEN), 32'd1);
    #3;
    nRST = 1'b0;
    #1;
    chk("midreset_ramWEN", 32'(ramWEN), 32'd0);
    chk("midreset_dwait", 32'(dwait), 32'd1);
    chk("midreset_ramaddr", ramaddr, 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    dWEN = 1'b0;
    planq.delete();
    ref_prio = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;

    predict(1, 0, 1'b0, 32'h3C, 32'h0, 32'h0, 2, K_ACC);
    serve(1, 0, 1'b0, 1'b0, 32'h3C, 32'h0, 32'h0);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    chk("plans_drained", planq.size(), 32'd0);
    chk("err_final", 32'(err), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
